// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: flit type codes, default sizes and FSM state encodings shared by the arbiter
package mux_arbiter_pkg;
  localparam int DEF_NREQ = 2;
  localparam int DEF_TYPEW = 2;
  localparam int DEF_SELW = 5;
  localparam int DEF_TMO = 64;
  localparam int DEF_CNTW = 7;
  typedef enum logic [DEF_TYPEW-1:0] {
    TYPE_NONE = 2'd0,
    TYPE_HEAD = 2'd1,
    TYPE_DATA = 2'd2,
    TYPE_TAIL = 2'd3
  } flit_type_e;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;
endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wins
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (|(req & (NREQ'(1) << ((int'(ptr) + i) % NREQ)))) begin
        gnt = NREQ'(1) << ((int'(ptr) + i) % NREQ);
        idx = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: wormhole round-robin arbiter driving the flit mux select, with lock watchdog
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int TYPEW = DEF_TYPEW,
  parameter int SELW = DEF_SELW,
  parameter int TMO = DEF_TMO,
  parameter int CNTW = DEF_CNTW
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NREQ-1:0]       ivalid,
  input  logic [NREQ*TYPEW-1:0] itype,
  input  logic                  ordy,
  output logic [SELW-1:0]       sel,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       irdy,
  output logic                  locked,
  output logic                  tmo_err
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_e state;
  logic [PW-1:0] rr_ptr, owner, pick_idx, nxt_ptr;
  logic [CNTW-1:0] wd_cnt;
  logic [NREQ-1:0] head_req, pick_gnt;
  logic [TYPEW-1:0] ftype [NREQ];
  logic own_vld, own_tail, wd_fire;
  for (genvar i = 0; i < NREQ; i++) begin : g_port
    assign ftype[i] = itype[i*TYPEW +: TYPEW];
    assign head_req[i] = ivalid[i] && ftype[i] == TYPE_HEAD;
  end
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req(head_req),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  // a HEAD seen on the owner while locked only matters as a non-TAIL flit
  assign own_vld = ivalid[owner];
  assign own_tail = own_vld && ordy && ftype[owner] == TYPE_TAIL;
  assign wd_fire = !own_vld && wd_cnt == CNTW'(TMO - 1);
  assign nxt_ptr = PW'((int'(owner) + 1) % NREQ);
  assign irdy = grant & {NREQ{ordy}};
  assign locked = state == ST_LOCKED;
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state <= ST_IDLE;
      grant <= '0;
      sel <= '0;
      owner <= '0;
      rr_ptr <= '0;
      wd_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_err <= 1'b0;
      if (state == ST_IDLE) begin
        wd_cnt <= '0;
        if (|head_req) begin
          state <= ST_LOCKED;
          grant <= pick_gnt;
          owner <= pick_idx;
          sel <= SELW'(pick_idx);
        end
      end else if (own_tail || wd_fire) begin
        state <= ST_IDLE;
        grant <= '0;
        wd_cnt <= '0;
        rr_ptr <= nxt_ptr;
        tmo_err <= wd_fire;
      end else begin
        wd_cnt <= own_vld ? '0 : wd_cnt + 1'b1;
      end
    end
  end
endmodule
